fir_seq_ctrl: RTL
=================

Name: fir_seq_ctrl

Overview:
- Sequencer placed in front of a single fir_1 instance. Buffers an incoming sample stream in a small FIFO.
- Drives the FIR's one-cycle act / ready protocol, one sample at a time.
- Returns each FIR result on a valid/ready output port, in input order.
- Replaces ad-hoc per-testbench drive logic, so fir_1 can be fed from any streaming source with backpressure.

Parameters:
DW, 16, sample and result width (matches fir_1 x/y)
ADDR_W, 2, FIFO address width; FIFO depth = 2**ADDR_W (default 4)
TIMEOUT_CYC, 64, max cycles to wait for fir_ready return (used only with FIR_TIMEOUT_EN)

Ports:
clk  in  1  clock, all logic on posedge
reset_p  in  1  asynchronous, active-high reset
s_valid  in  1  input sample valid
s_data  in  DW  input sample
s_ready  out  1  FIFO not full; transfer when s_valid && s_ready at posedge
m_valid  out  1  result valid
m_data  out  DW  FIR result
m_ready  in  1  downstream accepts result at posedge when m_valid && m_ready
fir_act  out  1  one-cycle start pulse to fir_1.act
fir_x  out  DW  sample to fir_1.x, registered, held until next issue
fir_ready  in  1  fir_1.ready (1 = idle/done)
fir_y  in  DW  fir_1.y
busy  out  1  1 when state != IDLE
fifo_level  out  ADDR_W+1  current FIFO occupancy, 0..2**ADDR_W
err_timeout  out  1  sticky FIR timeout flag

Behaviour:
- Reset is asynchronous and active-high on reset_p, clocked on clk.
- Reset values:
  - fir_act=0, fir_x=0, m_valid=0, m_data=0, err_timeout=0.
  - FIFO empty, fifo_level=0, state=IDLE, busy=0.
  - s_ready=1 after reset deassert.
- FIFO: registered, DEPTH entries, wrap-around pointers.
  - s_ready = (fifo_level != DEPTH).
  - Simultaneous push and pop leaves the level unchanged.
  - Pop occurs only in IDLE->ISSUE.
  - A push into an empty FIFO is visible to IDLE the next cycle (no fall-through).
- Output slot free (slot_free) = !m_valid || m_ready.
- FSM states: IDLE, ISSUE, WAIT_LO, WAIT_HI.
  - IDLE -> ISSUE when fifo_level!=0 && fir_ready && slot_free. On that edge: fir_x<=FIFO head, fir_act<=1, pop.
  - ISSUE: fir_act is high for exactly this one cycle. Next edge: fir_act<=0, go to WAIT_LO.
  - WAIT_LO: stay until fir_ready==0 is sampled, then go to WAIT_HI. fir_ready must drop for at least 1 cycle.
  - WAIT_HI: stay until fir_ready==1 is sampled. On that edge: m_data<=fir_y, m_valid<=1, go to IDLE.
- m_valid clears on the m_ready handshake unless a capture happens on the same edge.
  - Capture can only occur with the slot free, because issue required slot_free and m_valid cannot rise in between. No result is ever overwritten.
- Exactly one sample is in flight in the FIR at any time.
- Output order equals input order.
- Latency from an s handshake at edge k, controller idle, FIR ready, slot free:
  - fir_act is high in the cycle after edge k+1.
  - m_valid rises on the edge where fir_ready returns high, plus 0 cycles.
- m_valid held with m_ready=0 blocks further issues; the FIFO keeps accepting until full.
- Reset mid-operation returns everything to reset values; the in-flight sample and FIFO contents are discarded. fir_1 shares reset_p.
- fifo_level and busy are registered-state derived with no combinational path from inputs. s_ready depends only on fifo_level.

Optional Feature:
- Macro name: FIR_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to WAIT_LO and counts in WAIT_LO and WAIT_HI.
  - When it reaches TIMEOUT_CYC: err_timeout<=1 (sticky until reset), state->IDLE, sample dropped, no m_valid for it.
  - Subsequent samples proceed normally.
- Not defined: no counter; err_timeout tied to 0; WAIT_LO/WAIT_HI wait indefinitely.

Test Plan:
- After reset: push 100, 200, 300, 400 back-to-back, m_ready=1 -> four fir_act single-cycle pulses with fir_x=100,200,300,400 in order. m_data equals fir_y at each capture. fifo_level peaks at 3 or 4, never above 4.
- Push 5 samples with fir_ready held 0 externally -> s_ready=0 after the 4th push; the 5th is not accepted until the first issue; fifo_level=4 while full.
- m_ready=0 after the first result -> m_valid stays 1 with m_data stable; no second fir_act until m_ready=1. Then the next issue occurs within 1 cycle of slot_free with fir_ready=1.
- Assert reset_p for 3 cycles while in WAIT_HI with 2 samples queued -> all outputs return to reset values; after release, no fir_act and no m_valid until a new push.
- FIR_TIMEOUT_EN, TIMEOUT_CYC=8: model that never raises fir_ready after act -> err_timeout=1 after 8 cycles in wait. The next sample (300) issues and completes normally; err_timeout stays 1.
- Simultaneous push and pop at fifo_level=2 -> level remains 2, and the popped head is the oldest entry.

Source files
------------

// File: rtl/fir_seq_ctrl.sv
// Sequencer feeding a single fir_1: FIFO-buffered input stream, one sample in flight,
// results returned in order on a valid/ready port. `FIR_TIMEOUT_EN adds a wait watchdog.
module fir_seq_ctrl #(
   parameter int DW          = 16,
   parameter int ADDR_W      = 2,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic              clk,
   input  logic              reset_p,
   input  logic              s_valid,
   input  logic [DW-1:0]     s_data,
   output logic              s_ready,
   output logic              m_valid,
   output logic [DW-1:0]     m_data,
   input  logic              m_ready,
   output logic              fir_act,
   output logic [DW-1:0]     fir_x,
   input  logic              fir_ready,
   input  logic [DW-1:0]     fir_y,
   output logic              busy,
   output logic [ADDR_W:0]   fifo_level,
   output logic              err_timeout
);
   localparam int DEPTH = 2**ADDR_W;
   localparam logic [ADDR_W:0] FULL_LVL = DEPTH[ADDR_W:0];

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] ISSUE   = 2'd1;
   localparam logic [1:0] WAIT_LO = 2'd2;
   localparam logic [1:0] WAIT_HI = 2'd3;

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [ADDR_W:0]   level_q, level_d;
   logic [DW-1:0]     mem_q [DEPTH];
   logic              fir_act_q, fir_act_d;
   logic [DW-1:0]     fir_x_q, fir_x_d;
   logic              m_valid_q, m_valid_d;
   logic [DW-1:0]     m_data_q, m_data_d;
   logic              push, pop, slot_free, capture, timeout;

   assign s_ready   = (level_q != FULL_LVL);
   assign slot_free = !m_valid_q || m_ready;
   assign push      = s_valid && s_ready;
   assign pop       = (state_q == IDLE) && (level_q != '0) && fir_ready && slot_free;
   assign capture   = (state_q == WAIT_HI) && fir_ready;

`ifdef FIR_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
   logic             waiting;

   assign waiting     = (state_q == WAIT_LO) || (state_q == WAIT_HI);
   // A result arriving on the last allowed cycle still wins over the watchdog.
   assign timeout     = waiting && !capture && (cnt_q == CNT_LAST);
   assign err_timeout = err_q;

   always_comb begin
      cnt_d = cnt_q;
      err_d = err_q || timeout;
      if (state_q == ISSUE) cnt_d = '0;
      else if (waiting)     cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end
`else
   assign timeout     = 1'b0;
   assign err_timeout = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      fir_act_d = 1'b0;
      fir_x_d   = fir_x_q;
      m_valid_d = m_valid_q;
      m_data_d  = m_data_q;
      if (m_valid_q && m_ready) m_valid_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (pop) begin
               state_d   = ISSUE;
               fir_act_d = 1'b1;
               fir_x_d   = mem_q[rd_ptr_q];
            end
         end
         ISSUE:   state_d = WAIT_LO;
         WAIT_LO: if (!fir_ready) state_d = WAIT_HI;
         WAIT_HI: begin
            if (fir_ready) begin
               state_d   = IDLE;
               m_valid_d = 1'b1;
               m_data_d  = fir_y;
            end
         end
         default: state_d = IDLE;
      endcase
      if (timeout) state_d = IDLE;
   end

   always_comb begin
      level_d = level_q;
      case ({push, pop})
         2'b10:   level_d = level_q + (ADDR_W+1)'(1);
         2'b01:   level_d = level_q - (ADDR_W+1)'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         state_q   <= IDLE;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         level_q   <= '0;
         fir_act_q <= 1'b0;
         fir_x_q   <= '0;
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
      end else begin
         state_q   <= state_d;
         level_q   <= level_d;
         fir_act_q <= fir_act_d;
         fir_x_q   <= fir_x_d;
         m_valid_q <= m_valid_d;
         m_data_q  <= m_data_d;
         if (push) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
      end
   end

   // Storage carries no reset; occupancy is tracked by the pointers and level.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= s_data;
   end

   assign fir_act    = fir_act_q;
   assign fir_x      = fir_x_q;
   assign m_valid    = m_valid_q;
   assign m_data     = m_data_q;
   assign busy       = (state_q != IDLE);
   assign fifo_level = level_q;
endmodule
